// File: rtl/bouncing_ball_pkg.sv
// Shared constants, types and the per-axis motion helper for the bouncing-ball renderer.
package bouncing_ball_pkg;

  localparam int PIX_W        = 8;
  localparam int H_ACTIVE_DEF = 640;
  localparam int V_ACTIVE_DEF = 480;

  // RRRGGGBB colour constants
  localparam logic [PIX_W-1:0] RED    = 8'hE0;
  localparam logic [PIX_W-1:0] GREEN  = 8'h1C;
  localparam logic [PIX_W-1:0] BLUE   = 8'h03;
  localparam logic [PIX_W-1:0] CYAN   = 8'h1F;
  localparam logic [PIX_W-1:0] PINK   = 8'hF3;
  localparam logic [PIX_W-1:0] WHITE  = 8'hFF;
  localparam logic [PIX_W-1:0] BLACK  = 8'h00;
  localparam logic [PIX_W-1:0] YELLOW = 8'hFC;

  typedef enum logic {DIR_NEG = 1'b0, DIR_POS = 1'b1} dir_t;

  typedef struct packed {
    logic [9:0] pos;
    dir_t       dir;
    logic       hit;
  } axis_t;

  // One axis step; the sum is signed so moving below zero cannot wrap.
  function automatic axis_t axis_next(input logic [9:0] pos, input dir_t dir,
                                      input logic [3:0] step, input logic [9:0] lo,
                                      input logic [9:0] hi);
    logic signed [11:0] nxt;
    axis_t r;
    if (dir == DIR_POS) nxt = $signed({2'b00, pos}) + $signed({8'h00, step});
    else                nxt = $signed({2'b00, pos}) - $signed({8'h00, step});
    r = '{pos: nxt[9:0], dir: dir, hit: 1'b0};
    if (nxt > $signed({2'b00, hi}))      r = '{pos: hi, dir: DIR_NEG, hit: 1'b1};
    else if (nxt < $signed({2'b00, lo})) r = '{pos: lo, dir: DIR_POS, hit: 1'b1};
    return r;
  endfunction

endpackage

// File: rtl/bouncing_ball_motion.sv
// Ball position/direction registers for both axes; moves once per enabled frame_tick
// and pulses bounce for one cycle when either wall reflects.
module ball_motion
  import bouncing_ball_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int RADIUS   = 16,
  parameter int STEP_X   = 2,
  parameter int STEP_Y   = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_tick,
  input  logic       move_en,
  output logic [9:0] hcentre,
  output logic [9:0] vcentre,
  output logic       bounce
);

  localparam logic [9:0] LO     = 10'(RADIUS);
  localparam logic [9:0] X_HI   = 10'(H_ACTIVE - 1 - RADIUS);
  localparam logic [9:0] Y_HI   = 10'(V_ACTIVE - 1 - RADIUS);
  localparam logic [9:0] X_HOME = 10'(H_ACTIVE / 2);
  localparam logic [9:0] Y_HOME = 10'(V_ACTIVE / 2);

  dir_t  dir_x, dir_y;
  axis_t nx, ny;

  assign nx = axis_next(hcentre, dir_x, 4'(STEP_X), LO, X_HI);
  assign ny = axis_next(vcentre, dir_y, 4'(STEP_Y), LO, Y_HI);

  // NOTE: sequential state uses non-blocking assignment so every register samples
  // pre-edge values; blocking here would create order-dependent simulation results.
  always_ff @(posedge clk) begin
    if (rst) begin
      hcentre <= X_HOME;
      vcentre <= Y_HOME;
      dir_x   <= DIR_POS;
      dir_y   <= DIR_POS;
      bounce  <= 1'b0;
    end else begin
      bounce <= 1'b0;
      if (frame_tick && move_en) begin
        hcentre <= nx.pos;
        vcentre <= ny.pos;
        dir_x   <= nx.dir;
        dir_y   <= ny.dir;
        bounce  <= nx.hit | ny.hit;
      end
    end
  end

endmodule

// File: rtl/bouncing_ball.sv
// Ball over a background with a two-stage pixel pipeline (differences, then distance
// compare and colour select). Define BOUNCING_BALL_BRICK_EN for a brick-wall background.
module bouncing_ball
  import bouncing_ball_pkg::*;
#(
  parameter int               H_ACTIVE   = H_ACTIVE_DEF,
  parameter int               V_ACTIVE   = V_ACTIVE_DEF,
  parameter int               RADIUS     = 16,
  parameter int               STEP_X     = 2,
  parameter int               STEP_Y     = 1,
  parameter int               CELL_W     = 32,
  parameter int               CELL_H     = 16,
  parameter logic [PIX_W-1:0] BALL_COLOR = BLACK,
  parameter logic [PIX_W-1:0] LINE_COLOR = RED,
  parameter logic [PIX_W-1:0] FILL_COLOR = CYAN
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [9:0]       Hcounter,
  input  logic [9:0]       Vcounter,
  input  logic             frame_tick,
  input  logic             move_en,
  output logic [PIX_W-1:0] PixData,
  output logic [9:0]       Hcentre,
  output logic [9:0]       Vcentre,
  output logic             bounce
);

  localparam logic [21:0] R_SQ = 22'(RADIUS * RADIUS);

  ball_motion #(
    .H_ACTIVE(H_ACTIVE), .V_ACTIVE(V_ACTIVE), .RADIUS(RADIUS),
    .STEP_X(STEP_X), .STEP_Y(STEP_Y)
  ) u_motion (
    .clk(clk), .rst(rst), .frame_tick(frame_tick), .move_en(move_en),
    .hcentre(Hcentre), .vcentre(Vcentre), .bounce(bounce)
  );

  logic signed [10:0] dx, dy;
  logic               active_q;
  logic               active;
  logic               mortar;

  assign active = ({1'b0, Hcounter} < 11'(H_ACTIVE)) && ({1'b0, Vcounter} < 11'(V_ACTIVE));

`ifdef BOUNCING_BALL_BRICK_EN
  localparam int         CH_LOG  = $clog2(CELL_H);
  localparam logic [9:0] CW_MASK = 10'(CELL_W - 1);
  localparam logic [9:0] CW_HALF = 10'(CELL_W / 2);
  localparam logic [9:0] CH_MASK = 10'(CELL_H - 1);

  logic [9:0] row;
  logic       mortar_q;

  // Odd brick rows are offset by half a cell.
  assign row    = Vcounter >> CH_LOG;
  assign mortar = ((Vcounter & CH_MASK) == 10'd0) ||
                  (row[0] ? ((Hcounter & CW_MASK) == CW_HALF)
                          : ((Hcounter & CW_MASK) == 10'd0));
`else
  assign mortar = 1'b0;
`endif

  // NOTE: pipeline registers are cleared by the synchronous reset so the first two
  // output pixels after reset are deterministic black rather than stale data.
  always_ff @(posedge clk) begin
    if (rst) begin
      dx       <= '0;
      dy       <= '0;
      active_q <= 1'b0;
`ifdef BOUNCING_BALL_BRICK_EN
      mortar_q <= 1'b0;
`endif
    end else begin
      dx       <= $signed({1'b0, Hcounter}) - $signed({1'b0, Hcentre});
      dy       <= $signed({1'b0, Vcounter}) - $signed({1'b0, Vcentre});
      active_q <= active;
`ifdef BOUNCING_BALL_BRICK_EN
      mortar_q <= mortar;
`endif
    end
  end

  logic signed [21:0] dx_w, dy_w, dx_sq, dy_sq;
  logic        [21:0] dist2;
  logic [PIX_W-1:0]   bg;

  assign dx_w  = 22'(dx);
  assign dy_w  = 22'(dy);
  assign dx_sq = dx_w * dx_w;
  assign dy_sq = dy_w * dy_w;
  assign dist2 = $unsigned(dx_sq) + $unsigned(dy_sq);

  // NOTE: every always_comb output gets a default first, so no path leaves it unassigned
  // and no latch is inferred.
  always_comb begin
    bg = FILL_COLOR;
`ifdef BOUNCING_BALL_BRICK_EN
    if (mortar_q) bg = LINE_COLOR;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst)                PixData <= '0;
    else if (!active_q)     PixData <= '0;
    else if (dist2 <= R_SQ) PixData <= BALL_COLOR;
    else                    PixData <= bg;
  end

endmodule

// File: tb/tb_bouncing_ball.sv
// Scoreboard bench: three bouncing_ball configurations driven with random ticks and
// pixels, checked against an arithmetic model of ball motion and pixel colour.
`timescale 1ns/1ps
module tb_bouncing_ball;

  localparam int NI = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [9:0] hcnt = 10'd0;
  logic [9:0] vcnt = 10'd5;
  logic       frame_tick = 1'b0;
  logic       move_en = 1'b0;
  logic [7:0] pix [NI];
  logic [9:0] hc  [NI];
  logic [9:0] vc  [NI];
  logic       bn  [NI];

  always #5 clk = ~clk;

  bouncing_ball u_a (
    .clk(clk), .rst(rst), .Hcounter(hcnt), .Vcounter(vcnt), .frame_tick(frame_tick),
    .move_en(move_en), .PixData(pix[0]), .Hcentre(hc[0]), .Vcentre(vc[0]), .bounce(bn[0])
  );

  bouncing_ball #(.H_ACTIVE(40), .V_ACTIVE(40), .RADIUS(4), .STEP_X(3), .STEP_Y(3)) u_b (
    .clk(clk), .rst(rst), .Hcounter(hcnt), .Vcounter(vcnt), .frame_tick(frame_tick),
    .move_en(move_en), .PixData(pix[1]), .Hcentre(hc[1]), .Vcentre(vc[1]), .bounce(bn[1])
  );

  bouncing_ball #(.H_ACTIVE(40), .V_ACTIVE(30), .RADIUS(4), .STEP_X(0), .STEP_Y(5)) u_c (
    .clk(clk), .rst(rst), .Hcounter(hcnt), .Vcounter(vcnt), .frame_tick(frame_tick),
    .move_en(move_en), .PixData(pix[2]), .Hcentre(hc[2]), .Vcentre(vc[2]), .bounce(bn[2])
  );

  // Per-instance travel limits, step sizes and home positions, axis 0 = x, axis 1 = y.
  int lo   [NI][2] = '{'{16, 16}, '{4, 4}, '{4, 4}};
  int hi   [NI][2] = '{'{623, 463}, '{35, 35}, '{35, 25}};
  int step [NI][2] = '{'{2, 1}, '{3, 3}, '{0, 5}};
  int home [NI][2] = '{'{320, 240}, '{20, 20}, '{20, 15}};

  int mpos [NI][2];
  int mdir [NI][2];
  int mbounce [NI];

  typedef struct {
    int    due;
    bit    is_pix;
    int    inst;
    int    a;
    int    b;
    int    c;
    string name;
  } exp_t;

  exp_t sb[$];
  int cycle  = 0;
  int checks = 0;
  int errors = 0;

  always @(posedge clk) cycle <= cycle + 1;

  task automatic check(input string name, input int inst, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s inst%0d cycle %0d: got %0d expected %0d", name, inst, cycle, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NI; i++) begin
      for (int ax = 0; ax < 2; ax++) begin
        mpos[i][ax] = home[i][ax];
        mdir[i][ax] = 1;
      end
      mbounce[i] = 0;
    end
  endtask

  // Move by the step in the current direction; overshooting a limit parks the ball
  // on that limit and reverses it.
  task automatic model_tick();
    for (int i = 0; i < NI; i++) begin
      mbounce[i] = 0;
      for (int ax = 0; ax < 2; ax++) begin
        int n;
        n = mpos[i][ax] + mdir[i][ax] * step[i][ax];
        if (n > hi[i][ax]) begin
          mpos[i][ax] = hi[i][ax];
          mdir[i][ax] = -1;
          mbounce[i]  = 1;
        end else if (n < lo[i][ax]) begin
          mpos[i][ax] = lo[i][ax];
          mdir[i][ax] = 1;
          mbounce[i]  = 1;
        end else begin
          mpos[i][ax] = n;
        end
      end
    end
  endtask

  function automatic int pix_model(input int h, input int v);
    int ddx, ddy;
    if (h >= 640 || v >= 480) return 'h00;
    ddx = h - mpos[0][0];
    ddy = v - mpos[0][1];
    if (ddx * ddx + ddy * ddy <= 16 * 16) return 'h00;
`ifdef BOUNCING_BALL_BRICK_EN
    if (v % 16 == 0) return 'hE0;
    if ((v / 16) % 2 == 0 && h % 32 == 0) return 'hE0;
    if ((v / 16) % 2 == 1 && h % 32 == 16) return 'hE0;
`endif
    return 'h1F;
  endfunction

  task automatic push_motion(input int due, input string name);
    for (int i = 0; i < NI; i++) begin
      exp_t e;
      e.due = due; e.is_pix = 1'b0; e.inst = i;
      e.a = mpos[i][0]; e.b = mpos[i][1]; e.c = mbounce[i]; e.name = name;
      sb.push_back(e);
    end
  endtask

  task automatic push_pix_exp(input int due, input int exp, input string name);
    exp_t e;
    e.due = due; e.is_pix = 1'b1; e.inst = 0; e.a = exp; e.b = 0; e.c = 0; e.name = name;
    sb.push_back(e);
  endtask

  task automatic drive_pix(input int h, input int v, input string name);
    hcnt = 10'(h);
    vcnt = 10'(v);
    push_pix_exp(cycle + 2, pix_model(h, v), name);
  endtask

  // Monitor: compares every expectation whose due cycle has arrived.
  always @(negedge clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].due <= cycle) begin
        if (sb[i].due < cycle) check({sb[i].name, "_late"}, sb[i].inst, cycle, sb[i].due);
        else if (sb[i].is_pix) check(sb[i].name, 0, int'(pix[0]), sb[i].a);
        else begin
          check({sb[i].name, "_h"}, sb[i].inst, int'(hc[sb[i].inst]), sb[i].a);
          check({sb[i].name, "_v"}, sb[i].inst, int'(vc[sb[i].inst]), sb[i].b);
          check({sb[i].name, "_bounce"}, sb[i].inst, int'(bn[sb[i].inst]), sb[i].c);
        end
        sb.delete(i);
      end
    end
  end

  // One frame: tick, then a quiet cycle with a pixel probe near the ball, then idle.
  task automatic do_tick(input string name);
    @(negedge clk);
    frame_tick = 1'b1;
    if (move_en) model_tick();
    else for (int i = 0; i < NI; i++) mbounce[i] = 0;
    push_motion(cycle + 1, name);
    @(negedge clk);
    frame_tick = 1'b0;
    for (int i = 0; i < NI; i++) mbounce[i] = 0;
    push_motion(cycle + 1, {name, "_after"});
    begin
      int h, v;
      h = mpos[0][0] + int'($urandom_range(0, 40)) - 20;
      v = mpos[0][1] + int'($urandom_range(0, 40)) - 20;
      if (h < 0) h = 0;
      if (v < 0) v = 0;
      drive_pix(h, v, "probe");
    end
    @(negedge clk);
  endtask

  int dir_h [12] = '{320, 336, 337, 0, 16, 16, 700, 320, 320, 639, 640, 100};
  int dir_v [12] = '{240, 240, 240, 5, 20, 5, 5, 256, 257, 479, 100, 480};

  initial begin
    model_reset();
    repeat (3) @(negedge clk);
    // Still in reset: expect home positions, then a cleared pipeline for two cycles.
    push_motion(cycle + 1, "reset");
    push_pix_exp(cycle + 1, 'h00, "rst_pipe0");
    push_pix_exp(cycle + 2, 'h00, "rst_pipe1");
    push_pix_exp(cycle + 3, pix_model(0, 5), "first_pix");
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      drive_pix(dir_h[k], dir_v[k], "dir_pix");
    end
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      drive_pix(int'($urandom_range(0, 700)), int'($urandom_range(0, 520)), "rnd_pix");
    end
    repeat (3) @(negedge clk);

    move_en = 1'b1;
    for (int k = 0; k < 10; k++) do_tick("move10");
    push_pix_exp(cycle + 1, pix_model(hcnt, vcnt), "hold_pix");
    begin
      exp_t e;
      e.due = cycle + 1; e.is_pix = 1'b0; e.inst = 0;
      e.a = 340; e.b = 250; e.c = 0; e.name = "ten_ticks";
      sb.push_back(e);
    end
    @(negedge clk);

    for (int k = 0; k < 600; k++) begin
      move_en = ($urandom_range(0, 3) != 0);
      do_tick("rnd_move");
    end

    // Reset coinciding with a tick wins; then ticks with move_en low must not move.
    @(negedge clk);
    rst = 1'b1;
    frame_tick = 1'b1;
    move_en = 1'b1;
    model_reset();
    push_motion(cycle + 1, "rst_tick");
    @(negedge clk);
    rst = 1'b0;
    frame_tick = 1'b0;
    @(negedge clk);
    move_en = 1'b0;
    for (int k = 0; k < 5; k++) do_tick("frozen");
    move_en = 1'b1;
    for (int k = 0; k < 5; k++) do_tick("resume");

    for (int k = 0; k < 20 && sb.size() > 0; k++) @(negedge clk);
    check("drain", -1, sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
